// File: rtl/lc330_pkg.sv
// Shared types and constants for the LC330 boot loader.
package lc330_pkg;

    typedef enum logic [2:0] {CNT_HI, CNT_LO, WORD, CHK, RUN, ERR} state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned CNT_BYTES  = 2;

endpackage

// File: rtl/lc330_word_assembler.sv
// Collects MSB-first bytes into 32-bit words; flags the byte that completes a word.
module lc330_word_assembler
    import lc330_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic        o_word_ready,
    output logic [31:0] o_word
);

    localparam int unsigned IDX_W = $clog2(WORD_BYTES);

    logic [IDX_W-1:0] r_idx;
    logic [23:0]      r_shift;

    // The completed word includes the byte arriving on this transfer.
    assign o_word_ready = i_en && (r_idx == IDX_W'(WORD_BYTES - 1));
    assign o_word       = {r_shift, i_byte};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (i_en) begin
            r_idx   <= o_word_ready ? '0 : r_idx + 1'b1;
            r_shift <= {r_shift[15:0], i_byte};
        end
    end

endmodule

// File: rtl/lc330_boot_loader.sv
// Byte-stream boot loader: writes counted big-endian words to instruction memory,
// verifies an XOR checksum and then releases the processor reset.
module lc330_boot_loader
    import lc330_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_cpu_rst,
    output logic              o_done,
    output logic              o_err
);

    state_t      r_state, w_state_next;
    logic        r_live;
    logic [7:0]  r_cnt_hi;
    logic [15:0] r_count;
    logic [15:0] r_widx;
    logic [7:0]  r_xor;

    logic        w_xfer;
    logic [15:0] w_count;
    logic        w_oversize;
    logic        w_last_word;
    logic        w_word_ready;
    logic [31:0] w_word;

    assign w_xfer      = i_rx_valid && o_rx_ready;
    assign w_count     = {r_cnt_hi, i_rx_data};
    assign w_oversize  = 32'(w_count) > DEPTH;
    assign w_last_word = (r_widx + 16'd1) == r_count;

    lc330_word_assembler u_word_assembler (
        .clk          (clk),
        .rst          (rst),
        .i_en         (w_xfer && (r_state == WORD)),
        .i_byte       (i_rx_data),
        .o_word_ready (w_word_ready),
        .o_word       (w_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CNT_HI;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CNT_HI: if (w_xfer) w_state_next = CNT_LO;
            CNT_LO: begin
                if (w_xfer) begin
                    if (w_oversize)          w_state_next = ERR;
                    else if (w_count == '0)  w_state_next = CHK;
                    else                     w_state_next = WORD;
                end
            end
            WORD:   if (w_word_ready && w_last_word) w_state_next = CHK;
            CHK:    if (w_xfer) w_state_next = (i_rx_data == r_xor) ? RUN : ERR;
            default: w_state_next = r_state;
        endcase
    end

    // r_live holds ready low until the first edge after reset is released.
    always_comb begin
        o_rx_ready = r_live && (r_state inside {CNT_HI, CNT_LO, WORD, CHK});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live       <= 1'b0;
            r_cnt_hi     <= '0;
            r_count      <= '0;
            r_widx       <= '0;
            r_xor        <= '0;
            o_imem_we    <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_wdata <= '0;
            o_cpu_rst    <= 1'b1;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            r_live    <= 1'b1;
            o_imem_we <= w_word_ready;
            if (w_xfer && (r_state == CNT_HI)) r_cnt_hi <= i_rx_data;
            if (w_xfer && (r_state == CNT_LO)) r_count  <= w_count;
            if (w_xfer && (r_state != CHK))    r_xor    <= r_xor ^ i_rx_data;
            if (w_word_ready) begin
                o_imem_addr  <= r_widx[ADDR_W-1:0];
                o_imem_wdata <= w_word;
                r_widx       <= r_widx + 16'd1;
            end
            o_cpu_rst <= (w_state_next != RUN);
            o_done    <= (w_state_next == RUN);
            o_err     <= (w_state_next == ERR);
        end
    end

endmodule

// File: tb/tb_lc330_boot_loader.sv
// Randomised self-checking bench for lc330_boot_loader against a byte-count based model.
module tb_lc330_boot_loader;

    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;

    lc330_boot_loader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_rx_ready   (rx_ready),
        .o_imem_we    (imem_we),
        .o_imem_addr  (imem_addr),
        .o_imem_wdata (imem_wdata),
        .o_cpu_rst    (cpu_rst),
        .o_done       (done),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position in the stream is just the number of bytes accepted so far.
    int          m_n;
    int          m_cnt;
    logic [7:0]  m_hi;
    logic [7:0]  m_xor;
    logic [31:0] m_acc;
    int          m_status;   // 0 loading, 1 running, 2 failed
    bit          m_live;
    bit          m_we;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;

    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    task automatic model_reset();
        m_n = 0; m_cnt = 0; m_hi = 0; m_xor = 0; m_acc = 0;
        m_status = 0; m_live = 0; m_we = 0; m_addr = 0; m_wdata = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_n == 0) begin
            m_hi  = b;
            m_xor = m_xor ^ b;
        end else if (m_n == 1) begin
            m_cnt = int'({m_hi, b});
            m_xor = m_xor ^ b;
            if (m_cnt > int'(DEPTH)) m_status = 2;
        end else if (m_n < 2 + 4 * m_cnt) begin
            m_acc = {m_acc[23:0], b};
            m_xor = m_xor ^ b;
            if ((m_n - 2) % 4 == 3) begin
                m_we    = 1;
                m_addr  = 8'((m_n - 2) / 4);
                m_wdata = m_acc;
            end
        end else begin
            m_status = (b == m_xor) ? 1 : 2;
        end
        m_n++;
    endtask

    // Per-cycle compare, sampled mid-cycle; then advance the model across the next edge.
    always @(negedge clk) begin
        if (rst) model_reset();
        check("rx_ready",   32'(rx_ready),   32'(m_live && m_status == 0));
        check("imem_we",    32'(imem_we),    32'(m_we));
        check("imem_addr",  32'(imem_addr),  32'(m_addr));
        check("imem_wdata", imem_wdata,      m_wdata);
        check("cpu_rst",    32'(cpu_rst),    32'(m_status != 1));
        check("done",       32'(done),       32'(m_status == 1));
        check("err",        32'(err),        32'(m_status == 2));
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
        if (!rst) begin
            bit xfer;
            xfer = rx_valid && m_live && (m_status == 0);
            m_we = 0;
            if (xfer) model_byte(rx_data);
            m_live = 1;
        end
    end

    logic [7:0] g_s[$];

    task automatic build_stream(input logic [31:0] w[$], input bit bad);
        logic [7:0] x;
        g_s.delete();
        g_s.push_back(8'(w.size() >> 8));
        g_s.push_back(8'(w.size()));
        foreach (w[i]) begin
            g_s.push_back(w[i][31:24]);
            g_s.push_back(w[i][23:16]);
            g_s.push_back(w[i][15:8]);
            g_s.push_back(w[i][7:0]);
        end
        x = 8'h00;
        foreach (g_s[i]) x = x ^ g_s[i];
        g_s.push_back(bad ? ~x : x);
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        bit ok;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: byte 0x%0h not accepted within 100 cycles", b);
        end
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int max_gap);
        foreach (s[i]) send_byte(s[i], max_gap);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_we"},       32'(imem_we),  32'd0);
        check({tag, "_addr"},     32'(imem_addr), 32'd0);
        check({tag, "_wdata"},    imem_wdata,    32'd0);
        check({tag, "_cpu_rst"},  32'(cpu_rst),  32'd1);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_err"},      32'(err),      32'd0);
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_values("rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_good_load(input string tag);
        check({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() == 2) begin
            check({tag, "_a0"}, 32'(wr_addr_q[0]), 32'd0);
            check({tag, "_d0"}, wr_data_q[0], 32'h00C10005);
            check({tag, "_a1"}, 32'(wr_addr_q[1]), 32'd1);
            check({tag, "_d1"}, wr_data_q[1], 32'h01800000);
        end
        check({tag, "_done"},    32'(done),    32'd1);
        check({tag, "_err"},     32'(err),     32'd0);
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
    endtask

    logic [7:0]  good[$];
    logic [31:0] words[$];

    initial begin
        good = '{8'h00, 8'h02, 8'h00, 8'hC1, 8'h00, 8'h05, 8'h01, 8'h80, 8'h00, 8'h00, 8'h47};
        model_reset();

        // Good load, back to back
        reset_dut();
        for (int i = 0; i < 10; i++) send_byte(good[i], 0);
        send_byte(good[10], 0);
        check("good_cpu_rst_edge", 32'(cpu_rst), 32'd0);
        check("good_done_edge",    32'(done),    32'd1);
        settle();
        check_good_load("good");

        // Zero count
        reset_dut();
        send_stream('{8'h00, 8'h00, 8'h00}, 0);
        settle();
        check("zero_nwr",     32'(wr_addr_q.size()), 32'd0);
        check("zero_done",    32'(done),    32'd1);
        check("zero_cpu_rst", 32'(cpu_rst), 32'd0);

        // Bad checksum
        reset_dut();
        for (int i = 0; i < 10; i++) send_byte(good[i], 0);
        send_byte(8'h46, 0);
        settle();
        check("bad_nwr",      32'(wr_addr_q.size()), 32'd2);
        check("bad_err",      32'(err),      32'd1);
        check("bad_cpu_rst",  32'(cpu_rst),  32'd1);
        check("bad_rx_ready", 32'(rx_ready), 32'd0);

        // Oversize count, then bytes offered to a terminal loader
        reset_dut();
        send_stream('{8'h01, 8'h01}, 0);
        check("over_err_edge", 32'(err),      32'd1);
        check("over_rx_ready", 32'(rx_ready), 32'd0);
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (8) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        check("over_nwr", 32'(wr_addr_q.size()), 32'd0);
        check("over_err", 32'(err), 32'd1);

        // Good load with random gaps
        for (int r = 0; r < 3; r++) begin
            reset_dut();
            send_stream(good, 5);
            settle();
            check_good_load("gap");
        end

        // Reset in the middle of a load
        reset_dut();
        send_stream('{8'h00, 8'h02, 8'h00, 8'hC1}, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
        send_stream(good, 2);
        settle();
        check_good_load("midrst");

        // Count exactly DEPTH
        words.delete();
        for (int i = 0; i < int'(DEPTH); i++) words.push_back($urandom);
        build_stream(words, 0);
        reset_dut();
        send_stream(g_s, 0);
        settle();
        check("full_nwr",  32'(wr_addr_q.size()), DEPTH);
        if (wr_addr_q.size() == DEPTH) begin
            check("full_last_addr", 32'(wr_addr_q[DEPTH-1]), DEPTH - 1);
            check("full_last_data", wr_data_q[DEPTH-1], words[DEPTH-1]);
        end
        check("full_done", 32'(done), 32'd1);

        // Random loads
        for (int r = 0; r < 12; r++) begin
            bit bad;
            int n;
            n   = int'($urandom_range(8, 1));
            bad = 1'($urandom_range(1, 0));
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            build_stream(words, bad);
            reset_dut();
            send_stream(g_s, 3);
            settle();
            check("rnd_nwr", 32'(wr_addr_q.size()), 32'(n));
            if (wr_addr_q.size() == n) begin
                for (int i = 0; i < n; i++) begin
                    check("rnd_addr", 32'(wr_addr_q[i]), 32'(i));
                    check("rnd_data", wr_data_q[i], words[i]);
                end
            end
            check("rnd_done", 32'(done), 32'(!bad));
            check("rnd_err",  32'(err),  32'(bad));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lc330_boot_loader.md
Name: lc330_boot_loader

Overview:
- Loads an LC330 program into instruction memory, then releases the processor. It is the writer side of the instruction-memory interface that the processor core reads.
- Consumes a byte stream through a valid/ready handshake, for example from a UART receiver.
- Assembles big-endian 32-bit words and writes them to consecutive instruction-memory addresses.
- Verifies an XOR checksum, then deasserts cpu_rst so the core fetches from pc = 0.

Parameters:
- DEPTH, 256, instruction-memory depth in words; the maximum legal word count.
- ADDR_W, 8, instruction-memory address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle; a transfer occurs when rx_valid && rx_ready.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  write data.
- cpu_rst  out  1  processor reset, held high until the load succeeds.
- done  out  1  load succeeded; processor running.
- err  out  1  load failed; sticky until rst.

Behaviour:
- Stream format, in order:
  - count, 2 bytes, big-endian, value N.
  - N words, 4 bytes each, MSB first.
  - 1 checksum byte, equal to the XOR of every preceding byte, including the count bytes.
- Reset values:
  - rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, done=0, err=0.
  - State = CNT_HI; word index = 0; byte index = 0; running XOR = 0.
  - rx_ready rises on the first clk edge after rst falls.
- States and transitions:
  - CNT_HI: accept a byte into count[15:8], then go to CNT_LO.
  - CNT_LO: accept a byte into count[7:0], then:
    - count > DEPTH -> ERR;
    - count == 0 -> CHK;
    - otherwise -> WORD.
  - WORD: accept bytes into a shift register (MSB first).
    - On the 4th byte: the next cycle has imem_we=1, imem_wdata = assembled word, imem_addr = word index.
    - After that write the word index increments.
    - When the word index reaches count -> CHK.
    - rx_ready stays high during the write-strobe cycle, so back-to-back bytes are never stalled.
  - CHK: accept one byte.
    - Byte equals running XOR -> RUN.
    - Otherwise -> ERR.
  - RUN: rx_ready=0, cpu_rst=0, done=1. Terminal until rst.
  - ERR: rx_ready=0, cpu_rst=1, err=1, no further writes. Terminal until rst.
- Registered outputs:
  - cpu_rst, done and err are registered.
  - cpu_rst falls on the clk edge that enters RUN.
- Running XOR: updated on every accepted byte except the checksum byte itself.
- Handshake:
  - No byte is consumed unless rx_valid && rx_ready.
  - rx_valid gaps of any length are legal; state holds across them.
  - rx_data is sampled only on a transfer.
- Write rules:
  - At most one write per 4 accepted word bytes.
  - The address never exceeds count-1, so it never wraps.
  - A partial word left at reset is never written.
- Reset mid-load: all state returns to the reset values immediately and asynchronously. cpu_rst stays high and the next byte is treated as CNT_HI.
- Count width: 16 bits, with the comparison to DEPTH made at full width.

Decomposition:
- Shared package lc330_pkg holds:
  - state enum {CNT_HI, CNT_LO, WORD, CHK, RUN, ERR};
  - constant WORD_BYTES = 4;
  - constant CNT_BYTES = 2.
- One natural sub-module: lc330_word_assembler. It contains the byte-index counter and the 32-bit MSB-first shift register, and flags word_ready on the 4th byte.
- The FSM, the XOR accumulator and the address counter stay in the top module.

Test Plan:
- Good load. Stream 00 02 | 00 C1 00 05 | 01 80 00 00 | 47.
  - Required: writes addr0=0x00C10005 then addr1=0x01800000, one imem_we pulse each.
  - Required: cpu_rst falls one cycle after the 47 byte is accepted; done=1, err=0.
- Zero count. Stream 00 00 00.
  - Required: no imem_we pulses; done=1, cpu_rst=0.
- Bad checksum. Stream as in the good load but with last byte 46.
  - Required: both writes still occur; err=1, cpu_rst stays 1, rx_ready=0.
- Oversize count. With DEPTH=256, stream 01 01.
  - Required: err=1 the cycle after the second byte; no writes; rx_ready=0.
- Backpressure and gaps. Good-load stream with rx_valid deasserted for 0–5 random cycles between bytes.
  - Required: writes, addresses and final state identical to the good-load case.
- Reset mid-load. Assert rst after 00 02 00 C1, then send the full good-load stream.
  - Required: outputs return to reset values at once; exactly 2 writes occur afterwards; final done=1.
